// File: rtl/sifh_zoom_histogram.sv
// rtl/sifh_zoom_histogram.sv - multi-pass successive-zoom per-pixel histogram and peak detector
// Each pass re-bins the pixel stream in a window centred on the previous pass's peak.
`timescale 1ns/1ps
module sifh_zoom_histogram #(
  parameter int NP             = 12,
  parameter int NB             = 4,
  parameter int PIXELS         = 4,
  parameter int DATA_PER_PIXEL = 2,
  parameter int ACQ_NUM        = 16,
  parameter int PASSES         = 2,
  parameter int COUNT_W        = 8,
  localparam int PW            = (PIXELS > 1) ? $clog2(PIXELS) : 1,
  localparam int PSW           = $clog2(PASSES + 1)
) (
  input  logic               clk,
  input  logic               res,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NP-1:0]      in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PW-1:0]      out_pixel,
  output logic [NP-1:0]      out_peak,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_hit,
  output logic [PSW-1:0]     pass_idx,
  output logic               frame_done
);
  localparam int NBINS = 2 ** NB;
  localparam int AW    = NP + 2;
  localparam int DW    = (DATA_PER_PIXEL > 1) ? $clog2(DATA_PER_PIXEL) : 1;
  localparam int AQW   = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {CLEAR, ACCUM, DRAIN, UPDATE, OUTPUT} state_t;
  state_t state;

  logic [NP-1:0]      lo      [PIXELS];
  logic [PIXELS-1:0]  hit;
  logic [COUNT_W-1:0] max_cnt [PIXELS];
  logic [NB-1:0]      max_bin [PIXELS];
  logic [NBINS-1:0]   bin_vld [PIXELS];
  logic [COUNT_W-1:0] cnt     [PIXELS][NBINS];

  logic [PW-1:0]  cur_pix, upd_pix, s1_pix, ld_pix;
  logic [DW-1:0]  data_cnt;
  logic [AQW-1:0] acq_cnt;
  logic           drain_cnt, s1_valid;
  logic [NB-1:0]  s1_bin, in_bin;

  function automatic int shift_of(input int p);
    return NP - NB - p * (NB - 1);
  endfunction

  function automatic int wlog_of(input int p);
    return (p == 0) ? NP : shift_of(p - 1) + 1;
  endfunction

  function automatic logic [AW-1:0] pow2(input int e);
    return (e < 0) ? '0 : (AW'(1) << e);
  endfunction

  // Centre of bin b: also the reported peak and the next window's target centre.
  function automatic logic [AW-1:0] centre_of(input logic [NP-1:0] l, input logic [NB-1:0] b,
                                              input int s);
    return AW'(l) + (AW'(b) << s) + pow2(s - 1);
  endfunction

  int                 s_cur, w_cur;
  logic               xfer, last_xfer, in_win, upd_hit, ld_hit;
  logic [AW-1:0]      diff, tgt, raw_lo, max_lo;
  logic [NP-1:0]      new_lo, ld_peak;
  logic [COUNT_W-1:0] rd_cnt, nx_cnt;

  always_comb begin
    s_cur     = shift_of(int'(pass_idx));
    w_cur     = wlog_of(int'(pass_idx));
    xfer      = in_valid & in_ready;
    last_xfer = xfer && (cur_pix == PW'(PIXELS - 1)) && (data_cnt == DW'(DATA_PER_PIXEL - 1))
                && (acq_cnt == AQW'(ACQ_NUM - 1));
    diff      = AW'(in_data) - AW'(lo[cur_pix]);
    in_win    = !diff[AW-1] && (diff < pow2(w_cur));
    in_bin    = NB'(diff >> s_cur);
    // Counters live in flops, so a same-bin hit on the next cycle already sees this write.
    rd_cnt    = bin_vld[s1_pix][s1_bin] ? cnt[s1_pix][s1_bin] : '0;
    nx_cnt    = (rd_cnt == CNT_MAX) ? rd_cnt : rd_cnt + 1'b1;
    upd_hit   = (max_cnt[upd_pix] != '0);
    tgt       = upd_hit ? centre_of(lo[upd_pix], max_bin[upd_pix], s_cur)
                        : AW'(lo[upd_pix]) + pow2(w_cur - 1);
    raw_lo    = tgt - pow2(s_cur);
    max_lo    = pow2(NP) - pow2(s_cur + 1);
    if (raw_lo[AW-1])        new_lo = '0;
    else if (raw_lo > max_lo) new_lo = NP'(max_lo);
    else                      new_lo = NP'(raw_lo);
    ld_pix    = (state == OUTPUT) ? PW'(out_pixel + 1'b1) : '0;
    ld_hit    = hit[ld_pix] && (max_cnt[ld_pix] != '0);
    ld_peak   = ld_hit ? NP'(centre_of(lo[ld_pix], max_bin[ld_pix], s_cur)) : '0;
  end

  always_ff @(posedge clk) begin
    if (s1_valid) cnt[s1_pix][s1_bin] <= nx_cnt;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= CLEAR;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
      out_peak   <= '0;
      out_count  <= '0;
      out_hit    <= 1'b0;
      pass_idx   <= '0;
      frame_done <= 1'b0;
      hit        <= '1;
      cur_pix    <= '0;
      data_cnt   <= '0;
      acq_cnt    <= '0;
      drain_cnt  <= 1'b0;
      upd_pix    <= '0;
      s1_valid   <= 1'b0;
      s1_pix     <= '0;
      s1_bin     <= '0;
      for (int i = 0; i < PIXELS; i++) begin
        lo[i]      <= '0;
        max_cnt[i] <= '0;
        max_bin[i] <= '0;
        bin_vld[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      s1_valid   <= xfer & in_win;
      s1_pix     <= cur_pix;
      s1_bin     <= in_bin;
      if (s1_valid) begin
        bin_vld[s1_pix][s1_bin] <= 1'b1;
        if (nx_cnt > max_cnt[s1_pix]) begin
          max_cnt[s1_pix] <= nx_cnt;
          max_bin[s1_pix] <= s1_bin;
        end
      end
      case (state)
        CLEAR: begin
          for (int i = 0; i < PIXELS; i++) begin
            bin_vld[i] <= '0;
            max_cnt[i] <= '0;
            max_bin[i] <= '0;
          end
          cur_pix  <= '0;
          data_cnt <= '0;
          acq_cnt  <= '0;
          in_ready <= 1'b1;
          state    <= ACCUM;
        end
        ACCUM: if (xfer) begin
          if (data_cnt == DW'(DATA_PER_PIXEL - 1)) begin
            data_cnt <= '0;
            if (cur_pix == PW'(PIXELS - 1)) begin
              cur_pix <= '0;
              acq_cnt <= acq_cnt + 1'b1;
            end else begin
              cur_pix <= cur_pix + 1'b1;
            end
          end else begin
            data_cnt <= data_cnt + 1'b1;
          end
          if (last_xfer) begin
            in_ready  <= 1'b0;
            drain_cnt <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) begin
            upd_pix <= '0;
            state   <= UPDATE;
          end
        end
        UPDATE: begin
          if (!upd_hit) hit[upd_pix] <= 1'b0;
          if (pass_idx != PSW'(PASSES - 1)) lo[upd_pix] <= new_lo;
          upd_pix <= upd_pix + 1'b1;
          if (upd_pix == PW'(PIXELS - 1)) begin
            if (pass_idx == PSW'(PASSES - 1)) begin
              out_valid <= 1'b1;
              out_pixel <= ld_pix;
              out_peak  <= ld_peak;
              out_count <= max_cnt[ld_pix];
              out_hit   <= ld_hit;
              state     <= OUTPUT;
            end else begin
              pass_idx <= pass_idx + 1'b1;
              state    <= CLEAR;
            end
          end
        end
        OUTPUT: if (out_valid && out_ready) begin
          if (out_pixel == PW'(PIXELS - 1)) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
            pass_idx   <= '0;
            hit        <= '1;
            for (int i = 0; i < PIXELS; i++) lo[i] <= '0;
            state      <= CLEAR;
          end else begin
            out_pixel <= ld_pix;
            out_peak  <= ld_peak;
            out_count <= max_cnt[ld_pix];
            out_hit   <= ld_hit;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_sifh_zoom_histogram.sv
// tb/tb_sifh_zoom_histogram.sv - scoreboard bench for sifh_zoom_histogram
// A second instance with 2-bit counters shares the stimulus and checks saturation.
`timescale 1ns/1ps
module tb_sifh_zoom_histogram;
  logic        clk = 1'b0;
  logic        res;
  logic        in_valid;
  logic [11:0] in_data;
  logic        out_ready;
  logic        in_ready, out_valid, out_hit, frame_done;
  logic [0:0]  out_pixel;
  logic [11:0] out_peak;
  logic [7:0]  out_count;
  logic [1:0]  pass_idx;
  logic        in_ready_s, out_valid_s, out_hit_s, frame_done_s;
  logic [0:0]  out_pixel_s;
  logic [11:0] out_peak_s;
  logic [1:0]  out_count_s;
  logic [1:0]  pass_idx_s;

  always #5 clk = ~clk;

  sifh_zoom_histogram #(.NP(12), .NB(4), .PIXELS(2), .DATA_PER_PIXEL(2), .ACQ_NUM(4),
                        .PASSES(2), .COUNT_W(8)) u_dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_peak(out_peak),
    .out_count(out_count), .out_hit(out_hit), .pass_idx(pass_idx), .frame_done(frame_done));

  sifh_zoom_histogram #(.NP(12), .NB(4), .PIXELS(2), .DATA_PER_PIXEL(2), .ACQ_NUM(4),
                        .PASSES(2), .COUNT_W(2)) u_sat (
    .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_pixel(out_pixel_s),
    .out_peak(out_peak_s), .out_count(out_count_s), .out_hit(out_hit_s),
    .pass_idx(pass_idx_s), .frame_done(frame_done_s));

  typedef struct { int pix; logic [11:0] peak; int cnt; bit hit; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0, frames_done = 0, transfers = 0;
  bit   hold_mode = 0, held = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int pix, input logic [11:0] peak, input int cnt, input bit hit);
    exp_t e;
    e.pix = pix; e.peak = peak; e.cnt = cnt; e.hit = hit;
    exp_q.push_back(e);
  endtask

  // Hand-computed sample vectors per frame id, pass, acquisition, pixel, sample slot.
  function automatic logic [11:0] smp(input int f, input int p, input int a, input int x,
                                      input int d);
    case (f)
      1: return (x == 0) ? 12'h345 : 12'hFF0;
      2: if (x == 0) return 12'h010; else return (p == 0) ? 12'h345 : 12'h100;
      default: begin
        if (x == 0) return (p == 1 || a < 2) ? 12'h250 : 12'h550;
        return (d == 0) ? 12'h7A0 : 12'h7F0;
      end
    endcase
  endfunction

  task automatic push_frame(input int f);
    case (f)
      1: begin push_exp(0, 12'h350, 8, 1); push_exp(1, 12'hFF0, 8, 1); end
      2: begin push_exp(0, 12'h010, 8, 1); push_exp(1, 12'h000, 0, 0); end
      default: begin push_exp(0, 12'h250, 8, 1); push_exp(1, 12'h7B0, 4, 1); end
    endcase
  endtask

  task automatic send(input logic [11:0] d, input bit gaps);
    int t = 0;
    if (gaps)
      for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_pass(input int f, input int p, input int n, input bit gaps);
    int k = 0;
    for (int a = 0; a < 4; a++)
      for (int x = 0; x < 2; x++)
        for (int d = 0; d < 2; d++) begin
          if (k < n) send(smp(f, p, a, x, d), gaps);
          k++;
        end
  endtask

  task automatic run_frame(input int f, input bit gaps);
    int t = 0;
    push_frame(f);
    send_pass(f, 0, 16, gaps);
    while (pass_idx != 2'd1 && t < 20) begin @(negedge clk); t++; end
    chk("pass_idx_after_pass0", 32'(pass_idx), 32'd1);
    send_pass(f, 1, 16, gaps);
    t = 0;
    while (!frame_done && t < 100) begin @(negedge clk); t++; end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("frame_done_single_pulse", 32'(frame_done), 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [22:0] cap;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (frame_done) frames_done++;
      if (out_valid === 1'b1) begin
        if (hold_mode && !held) begin
          held = 1;
          out_ready = 1'b0;
          cap = {out_valid, out_pixel, out_peak, out_count, out_hit};
          for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_stable", 32'({out_valid, out_pixel, out_peak, out_count, out_hit}),
                32'(cap));
          end
          out_ready = 1'b1;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_pixel", 32'(out_pixel), 32'(e.pix));
          chk("out_peak",  32'(out_peak),  32'(e.peak));
          chk("out_count", 32'(out_count), 32'(e.cnt));
          chk("out_hit",   32'(out_hit),   32'(e.hit));
          chk("sat_valid", 32'(out_valid_s), 32'd1);
          chk("sat_pixel", 32'(out_pixel_s), 32'(e.pix));
          chk("sat_count", 32'(out_count_s), 32'((e.cnt > 3) ? 3 : e.cnt));
          transfers++;
        end
      end
    end
  end

  initial begin : driver
    res = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_pixel",  32'(out_pixel),  32'd0);
    chk("rst_out_peak",   32'(out_peak),   32'd0);
    chk("rst_out_count",  32'(out_count),  32'd0);
    chk("rst_out_hit",    32'(out_hit),    32'd0);
    chk("rst_pass_idx",   32'(pass_idx),   32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    res = 1'b0;
    @(negedge clk);
    run_frame(1, 0);
    run_frame(2, 1);
    run_frame(3, 0);
    hold_mode = 1;
    run_frame(1, 1);
    // Abort part-way through pass 1: nothing from this frame may appear.
    send_pass(2, 0, 16, 0);
    send_pass(2, 1, 6, 0);
    res = 1'b1;
    #1;
    chk("abort_in_ready",  32'(in_ready),  32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_pass_idx",  32'(pass_idx),  32'd0);
    @(negedge clk);
    res = 1'b0;
    #1;
    chk("abort_clear_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("abort_accum_in_ready", 32'(in_ready), 32'd1);
    chk("abort_accum_pass_idx", 32'(pass_idx), 32'd0);
    run_frame(1, 0);
    repeat (5) @(negedge clk);
    chk("frames_done", 32'(frames_done), 32'd5);
    chk("transfers", 32'(transfers), 32'd10);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
